ifft8_serial: RTL
=================

IFFT8_SERIAL -- requirements
Module: ifft8_serial

Interface
REQ-001 SHALL have parameter DW, default 67, the sample width, signed Q25.42.
REQ-002 SHALL have parameter TW, default 16, the twiddle width, signed Q2.14.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  frequency sample present.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample.
REQ-007 SHALL have ports in_real, in_imag  input  DW  frequency bin X[k], natural order k=0..7.
REQ-008 SHALL have port out_valid  output  1  time sample present.
REQ-009 SHALL have port out_ready  input  1  downstream accepts.
REQ-010 SHALL have ports out_real, out_imag  output  DW  time sample x[n], natural order n=0..7.
REQ-011 SHALL have port out_last  output  1  high with x[7].
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL compute the 8-point inverse DFT x[n] = (1/8)·Σ X[k]·e^(+j2πkn/8) on one frame of 8 complex samples.
REQ-014 SHALL implement an FSM with states IDLE, LOAD, COMPUTE and DRAIN; IDLE goes to LOAD on the first accepted sample; LOAD goes to COMPUTE on the 8th accept; COMPUTE goes to DRAIN after 12 butterfly cycles; DRAIN goes to IDLE on the handshake of x[7].
REQ-015 SHALL transfer an input on a clock edge with in_valid && in_ready; in_ready is high only in IDLE and LOAD.
REQ-016 SHALL write input number k into an 8-entry complex buffer at the 3-bit-reversed address of k.
REQ-017 SHALL run COMPUTE as radix-2 decimation in time over 3 stages, 4 butterflies per stage, one butterfly per cycle, results written in place; span = 2^(s-1) for stage s = 1..3.
REQ-018 SHALL use butterfly outputs a' = (a + W·b)>>>1 and b' = (a − W·b)>>>1, where >>> is an arithmetic shift; the three shifts together provide the 1/8 scale.
REQ-019 SHALL form the complex product W·b at full width (DW+TW), arithmetic-shift it right by 14 and truncate it to DW+1, and form the sum/difference at DW+1 bits before the final shift back to DW.
REQ-020 SHALL use conjugate twiddles W^-k in Q2.14, selected by k = j·4/span: k0=(16384,0), k1=(11585,11585), k2=(0,16384), k3=(−11585,11585).
REQ-021 SHALL assert the first out_valid on the 13th rising edge after the edge that accepts the 8th input.
REQ-022 SHALL keep out_real, out_imag and out_last stable while out_valid && !out_ready; the index advances only on a handshake.
REQ-023 SHALL return to IDLE on the x[7] handshake, with in_ready high on the following cycle; no new frame is accepted before that cycle.
REQ-024 SHALL not signal any error when in_valid is asserted during COMPUTE or DRAIN; the input is simply not accepted.

Reset
REQ-025 SHALL, on rst, enter IDLE, clear the sample counter and butterfly counter, and drive in_ready=1, out_valid=0, out_last=0, busy=0, out_real=0 and out_imag=0.
REQ-026 SHALL, on rst in any state (including mid-LOAD, COMPUTE or DRAIN), discard the partial frame; the buffer contents need not be cleared.
REQ-027 SHALL give rst priority over a simultaneous in or out handshake on the same edge.

Structure
REQ-028 SHALL place DW, TW, the twiddle constant table and the FSM state encodings in a shared package, ifft_pkg.
REQ-029 SHALL implement the butterfly datapath of REQ-018/019 as a combinational sub-module, ifft_butterfly, instantiated once.
REQ-030 SHALL hold the buffer in registers; no RAM macro is needed.

Verification
REQ-031 SHALL verify: impulse X[0]=(2^42,0), all other bins 0 -> every x[n] = (2^39, 0), exact.
REQ-032 SHALL verify: all X[k]=(2^42,0) -> x[0]=(2^42,0) and x[1..7]=(0,0), exact; out_last high only with x[7].
REQ-033 SHALL verify: X[1]=(2^45,0), all other bins 0 -> x[n] ≈ 2^42·e^(j2πn/8), each component within ±2^28 LSB; x[2]=(0,2^42) exact.
REQ-034 SHALL verify: out_ready held low for 5 cycles at x[3] -> x[3] held stable, no sample lost or duplicated, and 8 outputs in total.
REQ-035 SHALL verify: rst pulsed on the 6th COMPUTE cycle -> next cycle in IDLE with in_ready=1 and out_valid=0; the following frame gives the results of REQ-031.
REQ-036 SHALL verify: in_valid held high continuously -> exactly 8 accepts per frame, in_ready=0 throughout COMPUTE and DRAIN, and the next frame is accepted the cycle after x[7] is handshaken.

Source files
------------

// File: rtl/ifft_pkg.sv
// Shared constants, state encoding and twiddle table for the serial 8-point IFFT.
// Twiddles are the conjugates W^-k in Q2.14.
package ifft_pkg;
  localparam int DW      = 67;
  localparam int TW      = 16;
  localparam int TW_FRAC = 14;
  localparam int NBFLY   = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  localparam logic signed [TW-1:0] TW_RE [4] = '{16'sd16384, 16'sd11585, 16'sd0, -16'sd11585};
  localparam logic signed [TW-1:0] TW_IM [4] = '{16'sd0, 16'sd11585, 16'sd16384, 16'sd11585};

  function automatic logic [2:0] bitrev3(input logic [2:0] a);
    return {a[0], a[1], a[2]};
  endfunction
endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly with a halving shift on both outputs.
module ifft_butterfly #(
  parameter int DW   = ifft_pkg::DW,
  parameter int TW   = ifft_pkg::TW,
  parameter int FRAC = ifft_pkg::TW_FRAC
) (
  input  logic signed [DW-1:0] i_a_re,
  input  logic signed [DW-1:0] i_a_im,
  input  logic signed [DW-1:0] i_b_re,
  input  logic signed [DW-1:0] i_b_im,
  input  logic signed [TW-1:0] i_w_re,
  input  logic signed [TW-1:0] i_w_im,
  output logic signed [DW-1:0] o_a_re,
  output logic signed [DW-1:0] o_a_im,
  output logic signed [DW-1:0] o_b_re,
  output logic signed [DW-1:0] o_b_im
);
  localparam int PW = DW + TW;

  logic signed [PW-1:0] w_br_x, w_bi_x, w_wr_x, w_wi_x, w_pr, w_pi;
  logic signed [DW:0]   w_wb_re, w_wb_im, w_a_re_x, w_a_im_x;
  logic signed [DW:0]   w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  assign w_br_x = PW'(i_b_re);
  assign w_bi_x = PW'(i_b_im);
  assign w_wr_x = PW'(i_w_re);
  assign w_wi_x = PW'(i_w_im);

  // Full-width complex product, rescaled out of Q2.14 and kept one bit wider than a sample
  assign w_pr = w_br_x * w_wr_x - w_bi_x * w_wi_x;
  assign w_pi = w_bi_x * w_wr_x + w_br_x * w_wi_x;
  assign w_wb_re = (DW+1)'(w_pr >>> FRAC);
  assign w_wb_im = (DW+1)'(w_pi >>> FRAC);

  assign w_a_re_x = (DW+1)'(i_a_re);
  assign w_a_im_x = (DW+1)'(i_a_im);
  assign w_sum_re = w_a_re_x + w_wb_re;
  assign w_sum_im = w_a_im_x + w_wb_im;
  assign w_dif_re = w_a_re_x - w_wb_re;
  assign w_dif_im = w_a_im_x - w_wb_im;

  assign o_a_re = DW'(w_sum_re >>> 1);
  assign o_a_im = DW'(w_sum_im >>> 1);
  assign o_b_re = DW'(w_dif_re >>> 1);
  assign o_b_im = DW'(w_dif_im >>> 1);
endmodule

// File: rtl/ifft8_serial.sv
// Serial 8-point inverse FFT: loads 8 bins bit-reversed, runs 12 in-place
// butterflies, then streams x[0..7] with valid/ready handshakes.
module ifft8_serial #(
  parameter int DW = ifft_pkg::DW,
  parameter int TW = ifft_pkg::TW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_real,
  output logic signed [DW-1:0] out_imag,
  output logic                 out_last,
  output logic                 busy
);
  import ifft_pkg::*;

  state_e r_state, w_state_nxt;
  logic [2:0] r_in_cnt, r_out_idx;
  logic [3:0] r_bfly_cnt;
  logic signed [DW-1:0] r_buf_re [8];
  logic signed [DW-1:0] r_buf_im [8];
  logic r_in_ready, r_busy, r_out_valid, r_out_last;
  logic signed [DW-1:0] r_out_re, r_out_im;

  logic w_in_fire, w_out_fire, w_load_out, w_in_ready_nxt, w_busy_nxt;
  logic [2:0] w_top, w_bot;
  logic [1:0] w_tw_k;
  logic signed [TW-1:0] w_tw_re, w_tw_im;
  logic signed [DW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_in_fire) w_state_nxt = ST_LOAD; else w_state_nxt = ST_IDLE;
      ST_LOAD:    if (w_in_fire && r_in_cnt == 3'd7) w_state_nxt = ST_COMPUTE;
                  else w_state_nxt = ST_LOAD;
      ST_COMPUTE: if (r_bfly_cnt == 4'(NBFLY-1)) w_state_nxt = ST_DRAIN;
                  else w_state_nxt = ST_COMPUTE;
      ST_DRAIN:   if (w_out_fire && r_out_last) w_state_nxt = ST_IDLE;
                  else w_state_nxt = ST_DRAIN;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; flags are registered from the next state so they line up with it
  always_comb begin
    w_in_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    if (r_state == ST_DRAIN) begin
      w_load_out = !r_out_valid || (w_out_fire && !r_out_last);
    end else begin
      w_load_out = 1'b0;
    end
  end

  // Butterfly operand addresses and twiddle index for stage r_bfly_cnt[3:2]
  always_comb begin
    case (r_bfly_cnt[3:2])
      2'd0: begin
        w_top = {r_bfly_cnt[1:0], 1'b0};
        w_bot = {r_bfly_cnt[1:0], 1'b1};
        w_tw_k = 2'd0;
      end
      2'd1: begin
        w_top = {r_bfly_cnt[1], 1'b0, r_bfly_cnt[0]};
        w_bot = {r_bfly_cnt[1], 1'b1, r_bfly_cnt[0]};
        w_tw_k = {r_bfly_cnt[0], 1'b0};
      end
      2'd2: begin
        w_top = {1'b0, r_bfly_cnt[1:0]};
        w_bot = {1'b1, r_bfly_cnt[1:0]};
        w_tw_k = r_bfly_cnt[1:0];
      end
      default: begin
        w_top = 3'd0;
        w_bot = 3'd1;
        w_tw_k = 2'd0;
      end
    endcase
  end

  assign w_tw_re = TW'(TW_RE[w_tw_k]);
  assign w_tw_im = TW'(TW_IM[w_tw_k]);

  ifft_butterfly #(.DW(DW), .TW(TW)) u_bfly (
    .i_a_re(r_buf_re[w_top]), .i_a_im(r_buf_im[w_top]),
    .i_b_re(r_buf_re[w_bot]), .i_b_im(r_buf_im[w_bot]),
    .i_w_re(w_tw_re),         .i_w_im(w_tw_im),
    .o_a_re(w_a_re), .o_a_im(w_a_im), .o_b_re(w_b_re), .o_b_im(w_b_im)
  );

  // Sample buffer: bit-reversed load, in-place butterfly writeback
  always_ff @(posedge clk) begin
    if (!rst && w_in_fire) begin
      r_buf_re[bitrev3(r_in_cnt)] <= in_real;
      r_buf_im[bitrev3(r_in_cnt)] <= in_imag;
    end else if (!rst && r_state == ST_COMPUTE) begin
      r_buf_re[w_top] <= w_a_re;
      r_buf_im[w_top] <= w_a_im;
      r_buf_re[w_bot] <= w_b_re;
      r_buf_im[w_bot] <= w_b_im;
    end
  end

  // Counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_cnt    <= 3'd0;
      r_bfly_cnt  <= 4'd0;
      r_out_idx   <= 3'd0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else begin
      r_in_ready <= w_in_ready_nxt;
      r_busy     <= w_busy_nxt;
      if (w_in_fire) r_in_cnt <= r_in_cnt + 3'd1;
      if (r_state == ST_COMPUTE) begin
        r_bfly_cnt <= (r_bfly_cnt == 4'(NBFLY-1)) ? 4'd0 : r_bfly_cnt + 4'd1;
      end
      if (w_load_out) begin
        r_out_re    <= r_buf_re[r_out_idx];
        r_out_im    <= r_buf_im[r_out_idx];
        r_out_valid <= 1'b1;
        r_out_last  <= (r_out_idx == 3'd7);
        r_out_idx   <= r_out_idx + 3'd1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_real  = r_out_re;
  assign out_imag  = r_out_im;
endmodule
